// File: rtl/asm_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asm_alu_pkg
// Description : Opcodes, FSM state encoding and reserved-op mask shared by the
//               two-register execution unit and its combinational datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package asm_alu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MOV_AB = 4'h1;
    localparam logic [3:0] OP_MOV_BA = 4'h2;
    localparam logic [3:0] OP_LD_AX  = 4'h3;
    localparam logic [3:0] OP_LD_BX  = 4'h4;
    localparam logic [3:0] OP_ADD    = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_AND    = 4'h7;
    localparam logic [3:0] OP_OR     = 4'h8;
    localparam logic [3:0] OP_XOR    = 4'h9;
    localparam logic [3:0] OP_NOT    = 4'hA;
    localparam logic [3:0] OP_XCHG   = 4'hB;
    localparam logic [3:0] OP_SHL    = 4'hC;
    localparam logic [3:0] OP_SHR    = 4'hD;

    // One bit per opcode value; set bits are reserved encodings (1110, 1111).
    localparam logic [15:0] OP_RSVD_MASK = 16'hC000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/asm_alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : asm_alu_comb
// Description : Single-cycle result of one opcode: next AX/BX, flags and the
//               reserved-opcode indication. Multi-step shifts live in the top.
// Revision    : 1.0 - initial release
// ============================================================================
module asm_alu_comb
    import asm_alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [3:0]       kop,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] ax,
    input  logic [WIDTH-1:0] bx,
    output logic [WIDTH-1:0] new_ax,
    output logic [WIDTH-1:0] new_bx,
    output logic             zf,
    output logic             cf,
    output logic             upd_flags,
    output logic             ill
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, ax} + {1'b0, bx};

    always_comb begin
        new_ax    = ax;
        new_bx    = bx;
        cf        = 1'b0;
        upd_flags = 1'b0;
        case (kop)
            OP_MOV_AB: new_ax = bx;
            OP_MOV_BA: new_bx = ax;
            OP_LD_AX:  new_ax = imm;
            OP_LD_BX:  new_bx = imm;
            OP_ADD: begin
                new_ax    = w_sum[WIDTH-1:0];
                cf        = w_sum[WIDTH];
                upd_flags = 1'b1;
            end
            OP_SUB: begin
                new_ax    = ax - bx;
                cf        = (ax < bx);
                upd_flags = 1'b1;
            end
            OP_AND: begin
                new_ax    = ax & bx;
                upd_flags = 1'b1;
            end
            OP_OR: begin
                new_ax    = ax | bx;
                upd_flags = 1'b1;
            end
            OP_XOR: begin
                new_ax    = ax ^ bx;
                upd_flags = 1'b1;
            end
            OP_NOT: begin
                new_ax    = ~ax;
                upd_flags = 1'b1;
            end
            OP_XCHG: begin
                new_ax = bx;
                new_bx = ax;
            end
            // Only the zero-count shift is resolved here: AX kept, cf cleared.
            OP_SHL, OP_SHR: upd_flags = 1'b1;
            default: ;
        endcase
    end

    assign zf  = (new_ax == '0);
    assign ill = OP_RSVD_MASK[kop];

endmodule
`default_nettype wire

// File: rtl/asm_reg_alu.sv
`default_nettype none
// ============================================================================
// Module      : asm_reg_alu
// Description : Two-register (AX/BX) execution unit with ZF/CF flags, a
//               valid/ready opcode handshake and multi-cycle shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module asm_reg_alu
    import asm_alu_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       kop,
    input  logic [WIDTH-1:0] imm,
    input  logic             kop_valid,
    output logic             kop_ready,
    output logic [WIDTH-1:0] ax,
    output logic [WIDTH-1:0] bx,
    output logic             zf,
    output logic             cf,
    output logic             done,
    output logic             ill
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir_left;
    logic [WIDTH-1:0] r_ax;
    logic [WIDTH-1:0] r_bx;
    logic             r_zf;
    logic             r_cf;
    logic             r_done;
    logic             r_ill;

    logic [WIDTH-1:0] w_new_ax;
    logic [WIDTH-1:0] w_new_bx;
    logic             w_zf;
    logic             w_cf;
    logic             w_upd_flags;
    logic             w_ill;
    logic             w_accept;
    logic             w_start_shift;
    logic [SHW-1:0]   w_n;
    logic [WIDTH-1:0] w_sh_ax;
    logic             w_sh_out;

    asm_alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .kop       (kop),
        .imm       (imm),
        .ax        (r_ax),
        .bx        (r_bx),
        .new_ax    (w_new_ax),
        .new_bx    (w_new_bx),
        .zf        (w_zf),
        .cf        (w_cf),
        .upd_flags (w_upd_flags),
        .ill       (w_ill)
    );

    assign w_accept      = kop_valid && (r_state == ST_IDLE);
    assign w_n           = r_bx[SHW-1:0];
    assign w_start_shift = w_accept && ((kop == OP_SHL) || (kop == OP_SHR)) && (w_n != '0);

    // One shift step; the bit leaving AX becomes the carry.
    assign w_sh_ax  = r_dir_left ? {r_ax[WIDTH-2:0], 1'b0} : {1'b0, r_ax[WIDTH-1:1]};
    assign w_sh_out = r_dir_left ? r_ax[WIDTH-1] : r_ax[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_ax       <= '0;
            r_bx       <= '0;
            r_zf       <= 1'b0;
            r_cf       <= 1'b0;
            r_done     <= 1'b0;
            r_ill      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_shift) begin
                        r_state    <= ST_SHIFT;
                        r_cnt      <= w_n;
                        r_dir_left <= (kop == OP_SHL);
                    end else if (w_accept) begin
                        r_ax   <= w_new_ax;
                        r_bx   <= w_new_bx;
                        r_done <= 1'b1;
                        r_ill  <= w_ill;
                        if (w_upd_flags) begin
                            r_zf <= w_zf;
                            r_cf <= w_cf;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_ax  <= w_sh_ax;
                    r_cf  <= w_sh_out;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state <= ST_IDLE;
                        r_zf    <= (w_sh_ax == '0);
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign kop_ready = (r_state == ST_IDLE);
    assign ax        = r_ax;
    assign bx        = r_bx;
    assign zf        = r_zf;
    assign cf        = r_cf;
    assign done      = r_done;
    assign ill       = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_asm_reg_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_asm_reg_alu
// Description : Self-checking bench for asm_reg_alu at WIDTH=8 and WIDTH=3
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asm_reg_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] t_kop;
    logic [7:0] t_imm;
    logic       t_valid;
    logic       sel;

    logic       kv8, rdy8, zf8, cf8, done8, ill8;
    logic [7:0] ax8, bx8;
    logic       kv3, rdy3, zf3, cf3, done3, ill3;
    logic [2:0] ax3, bx3;

    logic       o_rdy, o_zf, o_cf, o_done, o_ill;
    logic [7:0] o_ax, o_bx;

    int total = 0;
    int bad   = 0;
    int m_ax, m_bx, m_zf, m_cf;

    always #5 clk = ~clk;

    assign kv8 = t_valid && !sel;
    assign kv3 = t_valid && sel;

    asm_reg_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .kop(t_kop), .imm(t_imm), .kop_valid(kv8),
        .kop_ready(rdy8), .ax(ax8), .bx(bx8), .zf(zf8), .cf(cf8),
        .done(done8), .ill(ill8)
    );

    asm_reg_alu #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .kop(t_kop), .imm(t_imm[2:0]), .kop_valid(kv3),
        .kop_ready(rdy3), .ax(ax3), .bx(bx3), .zf(zf3), .cf(cf3),
        .done(done3), .ill(ill3)
    );

    assign o_rdy  = sel ? rdy3  : rdy8;
    assign o_ax   = sel ? {5'b0, ax3} : ax8;
    assign o_bx   = sel ? {5'b0, bx3} : bx8;
    assign o_zf   = sel ? zf3   : zf8;
    assign o_cf   = sel ? cf3   : cf8;
    assign o_done = sel ? done3 : done8;
    assign o_ill  = sel ? ill3  : ill8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-instruction effect with plain integer arithmetic; lat = cycles
    // from the accepting edge to the retiring edge.
    function automatic void model(input int w, input int op, input int im,
                                  inout int a, inout int b, inout int z, inout int c,
                                  output int lat, output int il);
        int mask, shw, n, t;
        mask = (1 << w) - 1;
        shw  = 0;
        while ((1 << shw) < w) shw++;
        lat = 0;
        il  = 0;
        case (op)
            1:  a = b;
            2:  b = a;
            3:  a = im & mask;
            4:  b = im & mask;
            5:  begin t = a + b; c = (t > mask); a = t & mask; z = (a == 0); end
            6:  begin c = (a < b); a = (a - b) & mask; z = (a == 0); end
            7:  begin a = a & b; c = 0; z = (a == 0); end
            8:  begin a = a | b; c = 0; z = (a == 0); end
            9:  begin a = a ^ b; c = 0; z = (a == 0); end
            10: begin a = mask - a; c = 0; z = (a == 0); end
            11: begin t = a; a = b; b = t; end
            12, 13: begin
                n = b % (1 << shw);
                if (n == 0) c = 0;
                else if (op == 12) begin
                    c = (a >> (w - n)) & 1;
                    a = (a << n) & mask;
                end else begin
                    c = (a >> (n - 1)) & 1;
                    a = a >> n;
                end
                lat = n;
                z = (a == 0);
            end
            14, 15: il = 1;
            default: ;
        endcase
    endfunction

    task automatic exec(input int op, input int im);
        int lat, il, cyc;
        chk("ready_before_issue", o_rdy, 1);
        t_kop   = op[3:0];
        t_imm   = im[7:0];
        t_valid = 1'b1;
        model(sel ? 3 : 8, op, im, m_ax, m_bx, m_zf, m_cf, lat, il);
        @(posedge clk); #1;
        if (lat == 0) begin
            chk("done_single", o_done, 1);
            chk("ill", o_ill, il);
        end else begin
            chk("ready_busy", o_rdy, 0);
            chk("done_busy", o_done, 0);
            // Offer a different op while busy; it must not be taken.
            t_kop = 4'h3;
            t_imm = 8'h55;
            cyc   = 0;
            while (!o_done && cyc < lat + 3) begin
                @(posedge clk); #1;
                cyc++;
            end
            t_valid = 1'b0;
            chk("shift_latency", cyc, lat);
            chk("ill_shift", o_ill, 0);
        end
        chk("ax", o_ax, m_ax);
        chk("bx", o_bx, m_bx);
        chk("zf", o_zf, m_zf);
        chk("cf", o_cf, m_cf);
        chk("ready_after", o_rdy, 1);
    endtask

    task automatic idle_chk();
        t_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_idle", o_done, 0);
        chk("ax_idle", o_ax, m_ax);
        chk("bx_idle", o_bx, m_bx);
    endtask

    // Reset lands one step into a 3-step SHL: everything clears at once and no done follows.
    task automatic abort_shift();
        int dones;
        exec(4, 3);
        exec(3, 1);
        t_kop   = 4'hC;
        t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        chk("abort_busy", o_rdy, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ax", o_ax, 0);
        chk("rst_bx", o_bx, 0);
        chk("rst_zf", o_zf, 0);
        chk("rst_cf", o_cf, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ready", o_rdy, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ax = 0; m_bx = 0; m_zf = 0; m_cf = 0;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_ax", o_ax, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        t_valid = 1'b0;
        t_kop   = 4'h0;
        t_imm   = 8'h00;
        m_ax = 0; m_bx = 0; m_zf = 0; m_cf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ax", o_ax, 0);
        chk("reset_bx", o_bx, 0);
        chk("reset_flags", {o_zf, o_cf, o_done, o_ill}, 0);
        chk("reset_ready", o_rdy, 1);
        rst_n = 1'b1;

        // WIDTH=8 directed cases
        exec(3, 8'h0F); exec(4, 8'h3C); exec(7, 0);
        chk("and_result", o_ax, 8'h0C);
        exec(3, 8'hFF); exec(4, 8'h01); exec(5, 0);
        chk("add_wrap", {o_ax, o_zf, o_cf}, {8'h00, 1'b1, 1'b1});
        exec(6, 0);
        chk("sub_borrow", {o_ax, o_cf}, {8'hFF, 1'b1});
        idle_chk();
        exec(3, 8'h81); exec(4, 3); exec(12, 0);
        chk("shl3", {o_ax, o_cf}, {8'h08, 1'b0});
        idle_chk();
        chk("held_op_ignored", o_ax, 8'h08);
        exec(3, 8'hA5); exec(4, 0); exec(13, 0);
        chk("shr0", {o_ax, o_cf}, {8'hA5, 1'b0});
        exec(15, 8'h77);
        chk("ill_regs", {o_ax, o_bx, o_ill}, {8'hA5, 8'h00, 1'b1});
        exec(14, 0);
        idle_chk();

        for (int i = 0; i < 300; i++) begin
            exec(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) idle_chk();
        end
        idle_chk();
        abort_shift();

        // WIDTH=3 instance (both were just reset)
        sel = 1'b1;
        #1;
        chk("w3_reset_ax", o_ax, 0);
        exec(3, 5); exec(4, 6); exec(11, 0);
        chk("xchg", {o_ax, o_bx}, {8'd6, 8'd5});
        exec(4, 3); exec(3, 3); exec(12, 0);
        chk("w3_shl_full", {o_ax, o_cf, o_zf}, {8'd0, 1'b1, 1'b1});
        for (int i = 0; i < 150; i++) begin
            exec(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
        end
        idle_chk();
        abort_shift();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
